// File: rtl/demux8_seq_if.sv
// Bus bundle for the registered 1:8 demultiplexer: input beat, control and slot outputs.
interface demux8_seq_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0]   din;
  logic               din_valid;
  logic [2:0]         sel;
  logic               auto_en;
  logic               clr;
  logic [8*WIDTH-1:0] dout;
  logic [7:0]         ch_valid;
  logic [2:0]         slot_cnt;
  logic               frame_done;
  logic               ovf;

  modport master (
    output din, din_valid, sel, auto_en, clr,
    input  dout, ch_valid, slot_cnt, frame_done, ovf
  );

  modport slave (
    input  din, din_valid, sel, auto_en, clr,
    output dout, ch_valid, slot_cnt, frame_done, ovf
  );
endinterface

// File: rtl/demux8_seq.sv
// Registered 1:8 demultiplexer. Beats go to the slot named by sel (manual) or by
// an internal wrapping counter (auto, serial-to-parallel). Tracks slot occupancy,
// pulses frame_done after a full 8-beat auto frame, and flags manual overwrites.
module demux8_seq #(
  parameter int WIDTH = 1
) (
  input logic         clk,
  input logic         rst_n,
  demux8_seq_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, DONE = 2'd2} state_t;

  state_t             state_q, state_d;
  logic [8*WIDTH-1:0] dout_q, dout_d;
  logic [7:0]         ch_valid_q, ch_valid_d;
  logic [2:0]         slot_cnt_q, slot_cnt_d;
  logic               ovf_q, ovf_d;

  logic               auto_beat;
  logic               man_beat;
  logic [2:0]         slot;
  logic               frame_done;

  assign auto_beat = bus.din_valid && bus.auto_en;
  assign man_beat  = bus.din_valid && !bus.auto_en;
  assign slot      = bus.auto_en ? slot_cnt_q : bus.sel;

  // State register for the auto-mode framing FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: only auto beats advance framing; DONE always lasts one cycle.
  always_comb begin
    state_d = state_q;
    if (bus.clr) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (auto_beat) state_d = FILL;
        FILL:    if (auto_beat && slot_cnt_q == 3'd7) state_d = DONE;
        DONE:    state_d = auto_beat ? FILL : IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Output logic: frame_done is the DONE state itself, so it comes straight from a flop.
  always_comb begin
    frame_done = (state_q == DONE);
  end

  // Slot datapath: write the selected slot, restart occupancy on a new auto frame.
  always_comb begin
    dout_d     = dout_q;
    ch_valid_d = ch_valid_q;
    slot_cnt_d = slot_cnt_q;
    ovf_d      = ovf_q;
    if (bus.clr) begin
      dout_d     = '0;
      ch_valid_d = '0;
      slot_cnt_d = '0;
      ovf_d      = 1'b0;
    end else if (bus.din_valid) begin
      // An auto beat outside FILL is slot 0 of a fresh frame: old occupancy is dropped.
      if (auto_beat && state_q != FILL) ch_valid_d = '0;
      if (man_beat && ch_valid_q[slot]) ovf_d = 1'b1;
      for (int k = 0; k < 8; k++) begin
        if (slot == 3'(k)) begin
          dout_d[k*WIDTH +: WIDTH] = bus.din;
          ch_valid_d[k]            = 1'b1;
        end
      end
      if (auto_beat) slot_cnt_d = slot_cnt_q + 3'd1;
    end
  end

  // Slot, occupancy, counter and overflow registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q     <= '0;
      ch_valid_q <= '0;
      slot_cnt_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      dout_q     <= dout_d;
      ch_valid_q <= ch_valid_d;
      slot_cnt_q <= slot_cnt_d;
      ovf_q      <= ovf_d;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.ch_valid   = ch_valid_q;
  assign bus.slot_cnt   = slot_cnt_q;
  assign bus.frame_done = frame_done;
  assign bus.ovf        = ovf_q;

endmodule

// File: tb/tb_demux8_seq.sv
// Directed bench for demux8_seq (WIDTH=4) with a reference model feeding a scoreboard.
module tb_demux8_seq;
  localparam int W = 4;

  typedef struct packed {
    logic [8*W-1:0] dout;
    logic [7:0]     cv;
    logic [2:0]     cnt;
    logic           fd;
    logic           ovf;
  } exp_t;

  logic clk;
  logic rst_n;
  demux8_seq_if #(.WIDTH(W)) bus ();

  demux8_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  exp_t sb[$];

  // reference model state
  logic [W-1:0] m_slot [8];
  logic [7:0]   m_cv;
  logic [2:0]   m_cnt;
  logic         m_ovf;
  int           m_state;  // 0 idle, 1 fill, 2 done

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 8; k++) m_slot[k] = '0;
    m_cv = '0; m_cnt = '0; m_ovf = 1'b0; m_state = 0;
  endtask

  function automatic exp_t snapshot();
    exp_t e;
    for (int k = 0; k < 8; k++) e.dout[k*W +: W] = m_slot[k];
    e.cv = m_cv; e.cnt = m_cnt; e.fd = (m_state == 2); e.ovf = m_ovf;
    return e;
  endfunction

  task automatic model_step(input logic v, input logic [W-1:0] d, input logic [2:0] s,
                            input logic a, input logic c);
    if (c) begin
      model_reset();
    end else if (v && a) begin
      if (m_state != 1) begin
        m_cv = '0;
        m_state = 1;
      end else if (m_cnt == 3'd7) begin
        m_state = 2;
      end
      m_slot[m_cnt] = d;
      m_cv[m_cnt] = 1'b1;
      m_cnt = m_cnt + 3'd1;
    end else begin
      if (m_state == 2) m_state = 0;
      if (v) begin
        if (m_cv[s]) m_ovf = 1'b1;
        m_slot[s] = d;
        m_cv[s] = 1'b1;
      end
    end
  endtask

  task automatic check_sb();
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_empty", 64'(sb.size()), 64'd1);
      return;
    end
    e = sb.pop_front();
    chk("dout", 64'(bus.dout), 64'(e.dout));
    chk("ch_valid", 64'(bus.ch_valid), 64'(e.cv));
    chk("slot_cnt", 64'(bus.slot_cnt), 64'(e.cnt));
    chk("frame_done", 64'(bus.frame_done), 64'(e.fd));
    chk("ovf", 64'(bus.ovf), 64'(e.ovf));
  endtask

  // one clock of stimulus: drive, model, push expectation, then sample and compare
  task automatic step(input logic v, input logic [W-1:0] d, input logic [2:0] s,
                      input logic a, input logic c);
    bus.din_valid = v; bus.din = d; bus.sel = s; bus.auto_en = a; bus.clr = c;
    model_step(v, d, s, a, c);
    sb.push_back(snapshot());
    @(posedge clk);
    #1;
    bus.din_valid = 1'b0;
    bus.clr = 1'b0;
    check_sb();
  endtask

  initial begin
    rst_n = 1'b0;
    bus.din = '0; bus.din_valid = 1'b0; bus.sel = '0; bus.auto_en = 1'b0; bus.clr = 1'b0;
    model_reset();
    @(posedge clk); #1;
    chk("reset_dout", 64'(bus.dout), 64'd0);
    chk("reset_cv", 64'(bus.ch_valid), 64'd0);
    chk("reset_fd_ovf", {62'd0, bus.frame_done, bus.ovf}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // manual write, then overwrite of the same slot
    step(1'b1, 4'hA, 3'd3, 1'b0, 1'b0);
    chk("man_dout", 64'(bus.dout), 64'h0000_A000);
    chk("man_cv", 64'(bus.ch_valid), 64'h08);
    chk("man_ovf0", 64'(bus.ovf), 64'd0);
    step(1'b1, 4'h5, 3'd3, 1'b0, 1'b0);
    chk("ovr_slot3", 64'(bus.dout[15:12]), 64'h5);
    chk("ovr_ovf", 64'(bus.ovf), 64'd1);
    step(1'b0, 4'h0, 3'd0, 1'b0, 1'b0);
    chk("ovf_sticky", 64'(bus.ovf), 64'd1);
    step(1'b0, 4'h0, 3'd0, 1'b0, 1'b1);
    chk("clr_ovf", 64'(bus.ovf), 64'd0);

    // full auto frame of 8 beats
    for (int i = 1; i <= 8; i++) step(1'b1, 4'(i), 3'd0, 1'b1, 1'b0);
    chk("frame_dout", 64'(bus.dout), 64'h8765_4321);
    chk("frame_cv", 64'(bus.ch_valid), 64'hFF);
    chk("frame_cnt", 64'(bus.slot_cnt), 64'd0);
    chk("frame_fd", 64'(bus.frame_done), 64'd1);

    // 9th beat lands in the DONE cycle: start of the next frame
    step(1'b1, 4'h9, 3'd0, 1'b1, 1'b0);
    chk("b2b_dout", 64'(bus.dout), 64'h8765_4329);
    chk("b2b_cv", 64'(bus.ch_valid), 64'h01);
    chk("b2b_fd", 64'(bus.frame_done), 64'd0);
    chk("b2b_ovf", 64'(bus.ovf), 64'd0);
    step(1'b0, 4'h0, 3'd0, 1'b1, 1'b0);
    step(1'b0, 4'h0, 3'd0, 1'b1, 1'b1);

    // mode switch mid-frame
    for (int i = 0; i < 3; i++) step(1'b1, 4'(4'hB + i), 3'd0, 1'b1, 1'b0);
    step(1'b1, 4'h6, 3'd6, 1'b0, 1'b0);
    step(1'b1, 4'h3, 3'd0, 1'b1, 1'b0);
    chk("mode_slot3", 64'(bus.dout[15:12]), 64'h3);
    chk("mode_slot6", 64'(bus.dout[27:24]), 64'h6);
    chk("mode_cnt", 64'(bus.slot_cnt), 64'd4);
    chk("mode_cv", 64'(bus.ch_valid), 64'h4F);
    chk("mode_fd", 64'(bus.frame_done), 64'd0);

    // clr with a beat on the same edge, slot_cnt=6
    step(1'b1, 4'h1, 3'd0, 1'b1, 1'b0);
    step(1'b1, 4'h2, 3'd0, 1'b1, 1'b0);
    chk("pre_clr_cnt", 64'(bus.slot_cnt), 64'd6);
    step(1'b1, 4'hF, 3'd0, 1'b1, 1'b1);
    chk("clr_dout", 64'(bus.dout), 64'd0);
    chk("clr_cv", 64'(bus.ch_valid), 64'd0);
    chk("clr_cnt", 64'(bus.slot_cnt), 64'd0);

    // async reset mid-frame (slot_cnt=5)
    for (int i = 0; i < 5; i++) step(1'b1, 4'(4'h7 - i), 3'd0, 1'b1, 1'b0);
    chk("mid_cnt", 64'(bus.slot_cnt), 64'd5);
    rst_n = 1'b0;
    #1;
    chk("async_dout", 64'(bus.dout), 64'd0);
    chk("async_cv", 64'(bus.ch_valid), 64'd0);
    chk("async_cnt", 64'(bus.slot_cnt), 64'd0);
    chk("async_fd_ovf", {62'd0, bus.frame_done, bus.ovf}, 64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    step(1'b1, 4'hC, 3'd0, 1'b1, 1'b0);
    chk("post_rst_cv", 64'(bus.ch_valid), 64'h01);
    chk("post_rst_dout", 64'(bus.dout), 64'h0000_000C);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
